radix8_booth_pipe: RTL

Parametrised, pipelined radix-8 Booth multiplier with an optional running accumulator. It is the next-generation multiply element for the systolic-array processing element. Unlike the earlier multiplier/recoder pair, it computes 3Y internally, recodes X internally, and supports signed and unsigned operands per transaction. It also provides valid/ready flow control with backpressure and accumulate-in-place for dot-product chains.

---
 rtl/radix8_booth_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/radix8_booth_pipe.sv
// Three-stage radix-8 Booth multiplier with running accumulator and valid/ready flow control.
// Stage 1 recodes X and builds 3Y, stage 2 reduces the partial products, and stage 3 produces prod/acc.
module radix8_booth_pipe #(
    parameter int N     = 16,
    parameter int ACC_W = 2*N+8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic             is_signed,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   prod,
    output logic [ACC_W-1:0] acc
);

    localparam int K  = (N + 3) / 3;
    localparam int XW = 3 * K;
    localparam int W  = 2*N + 2;
    localparam int YW = N + 3;

    // digit encoding {neg, sel1, sel2, sel3, sel4}; window is {x[3i+2], x[3i+1], x[3i], x[3i-1]}
    function automatic logic [4:0] booth_enc(input logic [3:0] t);
        logic [4:0] d;
        case (t)
            4'b0001, 4'b0010: d = 5'b01000;
            4'b0011, 4'b0100: d = 5'b00100;
            4'b0101, 4'b0110: d = 5'b00010;
            4'b0111:          d = 5'b00001;
            4'b1000:          d = 5'b10001;
            4'b1001, 4'b1010: d = 5'b10010;
            4'b1011, 4'b1100: d = 5'b10100;
            4'b1101, 4'b1110: d = 5'b11000;
            default:          d = 5'b00000;
        endcase
        return d;
    endfunction

    logic                  w_adv1, w_adv2, w_adv3;
    logic [XW:0]           w_xb;
    logic [K-1:0][4:0]     w_dig;
    logic [N:0]            w_y_ext;
    logic [YW-1:0]         w_y_sx;
    logic [YW-1:0]         w_y3;
    logic [W-1:0]          w_sum;
    logic [ACC_W-1:0]      w_ext;
    logic [ACC_W-1:0]      w_acc_next;

    logic                  r_v1, r_v2, r_v3;
    logic [K-1:0][4:0]     r_dig;
    logic [N:0]            r_y;
    logic [YW-1:0]         r_y3;
    logic                  r_ae1, r_ae2;
    logic [W-1:0]          r_sum;
    logic [2*N-1:0]        r_prod;
    logic [ACC_W-1:0]      r_acc;

    assign w_adv3   = !r_v3 || out_ready;
    assign w_adv2   = !r_v2 || w_adv3;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    always_comb begin
        w_xb = '0;
        w_xb[N:1] = x;
        for (int b = N + 1; b <= XW; b++) begin
            w_xb[b] = is_signed & x[N-1];
        end
        w_dig = '0;
        for (int i = 0; i < K; i++) begin
            w_dig[i] = booth_enc(w_xb[3*i+3 -: 4]);
        end
    end

    assign w_y_ext = {is_signed & y[N-1], y};
    assign w_y_sx  = {{2{w_y_ext[N]}}, w_y_ext};
    assign w_y3    = (w_y_sx << 1) + w_y_sx;

    always_comb begin
        logic [YW-1:0] v_mag;
        logic [W-1:0]  v_pp;
        w_sum = '0;
        for (int i = 0; i < K; i++) begin
            v_mag = '0;
            if (r_dig[i][3]) v_mag = {{2{r_y[N]}}, r_y};
            if (r_dig[i][2]) v_mag = {r_y[N], r_y, 1'b0};
            if (r_dig[i][1]) v_mag = r_y3;
            if (r_dig[i][0]) v_mag = {r_y, 2'b00};
            v_pp = {{(W-YW){v_mag[YW-1]}}, v_mag};
            if (r_dig[i][4]) v_pp = ~v_pp;
            w_sum = w_sum + (v_pp << (3*i)) + (W'(r_dig[i][4]) << (3*i));
        end
    end

    // r_sum is the exact product in both modes (unsigned operands enter as non-negative),
    // so sign-extending it equals the mode-dependent extension of prod.
    generate
        if (ACC_W > W) begin : g_ext_wide
            assign w_ext = {{(ACC_W-W){r_sum[W-1]}}, r_sum};
        end else if (ACC_W == W) begin : g_ext_equal
            assign w_ext = r_sum;
        end else begin : g_ext_narrow
            assign w_ext = r_sum[ACC_W-1:0];
        end
    endgenerate

    // r_acc doubles as acc_prev: both load together whenever S3 takes a transaction
    assign w_acc_next = (r_ae2 ? r_acc : '0) + w_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_dig <= '0;
            r_y   <= '0;
            r_y3  <= '0;
            r_ae1 <= 1'b0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_dig <= w_dig;
                r_y   <= w_y_ext;
                r_y3  <= w_y3;
                r_ae1 <= acc_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2  <= 1'b0;
            r_sum <= '0;
            r_ae2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum <= w_sum;
                r_ae2 <= r_ae1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v3   <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_prod <= r_sum[2*N-1:0];
                r_acc  <= w_acc_next;
            end
        end
    end

    assign out_valid = r_v3;
    assign prod      = r_prod;
    assign acc       = r_acc;

endmodule
